// File: rtl/switch_arbiter_rr_if.sv
// Grant bundle between the per-port request logic (master) and the arbiter (slave).
// The arbiter drives the data-mux select (gnt/gnt_id) straight from these registered outputs.
interface switch_arbiter_rr_if #(
  parameter int N_PORTS = 9,
  parameter int ID_W    = $clog2(N_PORTS)
);
  // Handshake: req[i] is a level, held high for as long as port i wants the
  // shared output. Ownership begins on the edge after which gnt[i] reads high
  // and ends when req[i] is sampled low or the hold timeout fires. There is no
  // separate ready; gnt is the only acknowledgement.
  logic               rr_mode;
  logic               arb_en;
  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] gnt;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic               preempt;
  logic               dbg_own;

  modport master (
    output rr_mode, arb_en, req,
    input  gnt, gnt_valid, gnt_id, preempt, dbg_own
  );

  modport slave (
    input  rr_mode, arb_en, req,
    output gnt, gnt_valid, gnt_id, preempt, dbg_own
  );
endinterface

// File: rtl/switch_arbiter_rr.sv
// N-port grant arbiter: fixed-priority or round-robin, zero-bubble hand-off,
// and an optional maximum-hold timeout that pre-empts a long-running owner.
module switch_arbiter_rr #(
  parameter int N_PORTS  = 9,
  parameter int MAX_HOLD = 0,
  localparam int ID_W    = $clog2(N_PORTS)
) (
  input  logic               core_clock,
  input  logic               core_rst_n,
  switch_arbiter_rr_if.slave bus
);

  localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [ID_W:0]     N_W      = (ID_W + 1)'(N_PORTS);
  localparam logic [ID_W:0]     ONE_W    = (ID_W + 1)'(1);
  localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(N_PORTS - 1);
  localparam logic [N_PORTS-1:0] ONE_N   = N_PORTS'(1);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [N_PORTS-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               gnt_valid_q;
  logic               preempt_q, preempt_d;

  logic [N_PORTS-1:0]   cand;
  logic [2*N_PORTS-1:0] cand2;
  logic [N_PORTS-1:0]   rot;
  logic [ID_W:0]        rr_shift;
  logic [ID_W:0]        rr_sum;
  logic [ID_W-1:0]      rr_off;
  logic [ID_W-1:0]      fp_id;
  logic [ID_W-1:0]      win_id;
  logic                 win_found;
  logic                 owner_req;
  logic                 timeout;

  function automatic logic [ID_W-1:0] lowest_set(input logic [N_PORTS-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  // The current owner is masked out, so a releasing or timed-out port can
  // never win the arbitration that removes it. In IDLE gnt_q is zero.
  always_comb begin
    cand      = bus.req & ~gnt_q;
    win_found = |cand;
    fp_id     = lowest_set(cand);
    // Round-robin: rotate a doubled copy so the search starts at rr_ptr+1,
    // then map the offset back to a port index modulo N_PORTS.
    cand2     = {cand, cand};
    rr_shift  = {1'b0, rr_ptr_q} + ONE_W;
    rot       = N_PORTS'(cand2 >> rr_shift);
    rr_off    = lowest_set(rot);
    rr_sum    = {1'b0, rr_ptr_q} + {1'b0, rr_off} + ONE_W;
    if (rr_sum >= N_W) rr_sum = rr_sum - N_W;
    win_id    = bus.rr_mode ? rr_sum[ID_W-1:0] : fp_id;
  end

  assign owner_req = |(bus.req & gnt_q);
  assign timeout   = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && owner_req;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.arb_en && win_found) begin
          state_d  = OWN;
          gnt_d    = ONE_N << win_id;
          gnt_id_d = win_id;
          rr_ptr_d = win_id;
          hold_d   = HOLD_ONE;
        end
      end
      OWN: begin
        if (owner_req && !timeout) begin
          if (hold_q != '1) hold_d = hold_q + HOLD_ONE;
        end else begin
          // Release and timeout share one path; only preempt tells them apart.
          preempt_d = timeout;
          if (bus.arb_en && win_found) begin
            gnt_d    = ONE_N << win_id;
            gnt_id_d = win_id;
            rr_ptr_d = win_id;
            hold_d   = HOLD_ONE;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            hold_d   = '0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        hold_d   = '0;
      end
    endcase
  end

  always_ff @(posedge core_clock or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      rr_ptr_q    <= LAST_ID;
      hold_q      <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_q      <= hold_d;
      gnt_valid_q <= |gnt_d;
      preempt_q   <= preempt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.preempt   = preempt_q;
  assign bus.dbg_own   = (state_q == OWN);

endmodule

// File: tb/tb_switch_arbiter_rr.sv
// Directed bench for switch_arbiter_rr: one instance with MAX_HOLD=4 and one
// with the timeout disabled, both driven by the same request stimulus.
module tb_switch_arbiter_rr;

  logic       clk;
  logic       rst_n;
  logic       rr_mode;
  logic       arb_en;
  logic [8:0] req;

  int errors = 0;
  int checks = 0;

  switch_arbiter_rr_if #(.N_PORTS(9)) if4 ();
  switch_arbiter_rr_if #(.N_PORTS(9)) if0 ();

  assign if4.req     = req;
  assign if4.rr_mode = rr_mode;
  assign if4.arb_en  = arb_en;
  assign if0.req     = req;
  assign if0.rr_mode = rr_mode;
  assign if0.arb_en  = arb_en;

  switch_arbiter_rr #(.N_PORTS(9), .MAX_HOLD(4)) dut4 (
    .core_clock (clk),
    .core_rst_n (rst_n),
    .bus        (if4)
  );

  switch_arbiter_rr #(.N_PORTS(9), .MAX_HOLD(0)) dut0 (
    .core_clock (clk),
    .core_rst_n (rst_n),
    .bus        (if0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] idx_of(input logic [8:0] g);
    logic [3:0] r;
    r = '0;
    for (int i = 8; i >= 0; i--) begin
      if (g[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Every-cycle structural checks on both instances.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot4", 32'($onehot0(if4.gnt)), 32'd1);
      chk("valid4", 32'(if4.gnt_valid), 32'(|if4.gnt));
      chk("id4", 32'(if4.gnt_id), 32'(|if4.gnt ? idx_of(if4.gnt) : 4'd0));
      chk("onehot0", 32'($onehot0(if0.gnt)), 32'd1);
      chk("valid0", 32'(if0.gnt_valid), 32'(|if0.gnt));
      chk("id0", 32'(if0.gnt_id), 32'(|if0.gnt ? idx_of(if0.gnt) : 4'd0));
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [8:0] exp_g;
    rst_n   = 1'b0;
    rr_mode = 1'b0;
    arb_en  = 1'b1;
    req     = 9'h1FF;

    // Reset holds everything at zero despite full requests.
    #12;
    chk("rst_gnt", 32'(if4.gnt), 32'h0);
    chk("rst_id", 32'(if4.gnt_id), 32'h0);
    chk("rst_pre", 32'(if4.preempt), 32'h0);
    chk("rst_valid", 32'(if4.gnt_valid), 32'h0);
    chk("rst_own", 32'(if4.dbg_own), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("first_gnt", 32'(if4.gnt), 32'h001);
    chk("first_own", 32'(if4.dbg_own), 32'h1);
    req = 9'h000;
    step();
    chk("rel_idle", 32'(if4.gnt), 32'h000);

    // Fixed-priority with zero-bubble hand-off.
    req = 9'h00C;
    step();
    chk("fp_gnt2", 32'(if4.gnt), 32'h004);
    chk("fp_gnt2_n", 32'(if0.gnt), 32'h004);
    chk("fp_id2", 32'(if4.gnt_id), 32'd2);
    req = 9'h008;
    step();
    chk("fp_hand3", 32'(if4.gnt), 32'h008);
    chk("fp_hand3_n", 32'(if0.gnt), 32'h008);
    chk("fp_id3", 32'(if4.gnt_id), 32'd3);
    req = 9'h000;
    step();
    chk("fp_idle", 32'(if4.gnt), 32'h000);

    // Fresh reset, then round-robin fairness with full requests.
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n   = 1'b1;
    rr_mode = 1'b1;
    req     = 9'h1FF;
    step();
    chk("rr_start", 32'(if4.gnt), 32'h001);
    for (int k = 0; k < 9; k++) begin
      req = 9'h1FF;
      step();
      exp_g = 9'(1) << k;
      chk("rr_hold", 32'(if4.gnt), 32'(exp_g));
      req = 9'h1FF & ~(9'(1) << k);
      step();
      exp_g = 9'(1) << ((k + 1) % 9);
      chk("rr_next", 32'(if4.gnt), 32'(exp_g));
      chk("rr_next_n", 32'(if0.gnt), 32'(exp_g));
    end
    req = 9'h000;
    step();
    chk("rr_idle", 32'(if4.gnt), 32'h000);

    // Timeout with a sole requester: 4 cycles, one-cycle gap, re-grant.
    rr_mode = 1'b0;
    req     = 9'h008;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("to_hold", 32'(if4.gnt), 32'h008);
      chk("to_nopre", 32'(if4.preempt), 32'h0);
    end
    step();
    chk("to_drop", 32'(if4.gnt), 32'h000);
    chk("to_pre", 32'(if4.preempt), 32'h1);
    chk("to_own", 32'(if4.dbg_own), 32'h0);
    chk("nt_keep", 32'(if0.gnt), 32'h008);
    chk("nt_nopre", 32'(if0.preempt), 32'h0);
    step();
    chk("to_regnt", 32'(if4.gnt), 32'h008);
    chk("to_pre_clr", 32'(if4.preempt), 32'h0);

    // Timeout with a competitor: hand-off on the timeout edge.
    req = 9'h028;
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("to2_hold", 32'(if4.gnt), 32'h008);
    end
    step();
    chk("to2_hand", 32'(if4.gnt), 32'h020);
    chk("to2_pre", 32'(if4.preempt), 32'h1);
    chk("nt2_keep", 32'(if0.gnt), 32'h008);
    step();
    chk("to2_stay", 32'(if4.gnt), 32'h020);
    chk("to2_pre_clr", 32'(if4.preempt), 32'h0);
    req = 9'h000;
    step();
    chk("to2_idle", 32'(if4.gnt), 32'h000);
    chk("nt2_idle", 32'(if0.gnt), 32'h000);

    // arb_en=0: owner keeps grant, no hand-off, grant resumes when enabled.
    req = 9'h002;
    step();
    chk("en_gnt1", 32'(if4.gnt), 32'h002);
    arb_en = 1'b0;
    req    = 9'h012;
    step();
    chk("en_keep", 32'(if4.gnt), 32'h002);
    req = 9'h010;
    step();
    chk("en_nohand", 32'(if4.gnt), 32'h000);
    step();
    chk("en_wait", 32'(if4.gnt), 32'h000);
    chk("en_wait_n", 32'(if0.gnt), 32'h000);
    arb_en = 1'b1;
    step();
    chk("en_gnt4", 32'(if4.gnt), 32'h010);
    chk("en_id4", 32'(if4.gnt_id), 32'd4);
    req = 9'h000;
    step();
    chk("en_idle", 32'(if4.gnt), 32'h000);

    // Asynchronous reset between edges while port 8 owns the grant.
    rr_mode = 1'b1;
    req     = 9'h100;
    step();
    chk("ar_gnt8", 32'(if4.gnt), 32'h100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_drop", 32'(if4.gnt), 32'h000);
    chk("ar_drop_n", 32'(if0.gnt), 32'h000);
    chk("ar_valid", 32'(if4.gnt_valid), 32'h0);
    chk("ar_id", 32'(if4.gnt_id), 32'h0);
    chk("ar_pre", 32'(if4.preempt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 9'h1FF;
    step();
    chk("ar_restart", 32'(if4.gnt), 32'h001);
    chk("ar_restart_n", 32'(if0.gnt), 32'h001);
    req = 9'h000;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
